// File: rtl/tetris_renderer_if.sv
// rtl/tetris_renderer_if.sv - engine query and VGA output bundle for the Tetris renderer
interface tetris_renderer_if;
   logic [11:0] display_query_pos;
   logic [2:0]  display_query_res;
   logic [2:0]  next_piece;
   logic        game_over;
   logic        hsync;
   logic        vsync;
   logic [7:0]  rgb;
   logic        frame_start;

   modport master (
      output display_query_pos, hsync, vsync, rgb, frame_start,
      input  display_query_res, next_piece, game_over
   );

   modport slave (
      input  display_query_pos, hsync, vsync, rgb, frame_start,
      output display_query_res, next_piece, game_over
   );
endinterface

// File: rtl/tetris_renderer.sv
// rtl/tetris_renderer.sv - 640x480@60 scanner drawing the 10x20 playfield, border and preview in RGB332
module tetris_renderer #(
   parameter int CELL_PX  = 16,
   parameter int FIELD_X0 = 240,
   parameter int FIELD_Y0 = 80
) (
   input logic         clk,
   input logic         reset,
   tetris_renderer_if.master bus
);
   localparam int CSH = $clog2(CELL_PX);

   localparam logic [9:0] H_LAST  = 10'd799;
   localparam logic [9:0] V_LAST  = 10'd524;
   localparam logic [9:0] H_VIS   = 10'd640;
   localparam logic [9:0] V_VIS   = 10'd480;
   localparam logic [9:0] HS_BEG  = 10'd656;
   localparam logic [9:0] HS_END  = 10'd751;
   localparam logic [9:0] VS_BEG  = 10'd490;
   localparam logic [9:0] VS_END  = 10'd491;

   localparam logic [9:0] FX0  = 10'(FIELD_X0);
   localparam logic [9:0] FX1  = 10'(FIELD_X0 + 10 * CELL_PX);
   localparam logic [9:0] FY0  = 10'(FIELD_Y0);
   localparam logic [9:0] FY1  = 10'(FIELD_Y0 + 20 * CELL_PX);
   localparam logic [9:0] BX0  = 10'(FIELD_X0 - 4);
   localparam logic [9:0] BX1  = 10'(FIELD_X0 + 10 * CELL_PX + 4);
   localparam logic [9:0] BY0  = 10'(FIELD_Y0 - 4);
   localparam logic [9:0] BY1  = 10'(FIELD_Y0 + 20 * CELL_PX + 4);
   localparam logic [9:0] PX0  = 10'(FIELD_X0 + 11 * CELL_PX);
   localparam logic [9:0] PX1  = 10'(FIELD_X0 + 12 * CELL_PX);
   localparam logic [9:0] PY1  = 10'(FIELD_Y0 + CELL_PX);
   localparam logic [9:0] LAX0 = 10'(FIELD_X0 - CELL_PX);
   localparam logic [9:0] LAX1 = 10'(FIELD_X0 + 9 * CELL_PX);

   localparam logic [11:0] O_MASK  = 12'(CELL_PX - 1);
   localparam logic [11:0] O_ISSUE = 12'(CELL_PX - 4);
   localparam logic [11:0] O_CAPT  = 12'(CELL_PX - 1);

   logic [9:0]  h;
   logic [9:0]  v;
   logic [2:0]  cell_reg;
   logic [11:0] query_pos;
   logic [7:0]  rgb_reg;
   logic        hsync_reg;
   logic        vsync_reg;
   logic        frame_start_reg;

   logic        in_vis;
   logic        in_field;
   logic        in_border;
   logic        in_preview;
   logic        la_win;
   logic [11:0] rel;
   logic [11:0] offset;
   logic [11:0] row;
   logic [11:0] col;
   logic [11:0] query_next;
   logic [7:0]  rgb_next;

   function automatic logic [7:0] palette(input logic [2:0] id);
      case (id)
         3'd1:    palette = 8'hE0;
         3'd2:    palette = 8'hA3;
         3'd3:    palette = 8'h1C;
         3'd4:    palette = 8'hFC;
         3'd5:    palette = 8'hF0;
         3'd6:    palette = 8'h03;
         3'd7:    palette = 8'h1F;
         default: palette = 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
         h <= h + 10'd1;
      end
   end

   // The lookahead window starts one cell left of the field so each cell is fetched while the previous one is drawn.
   always_comb begin
      in_vis     = (h < H_VIS) && (v < V_VIS);
      in_field   = (h >= FX0) && (h < FX1) && (v >= FY0) && (v < FY1);
      in_border  = (h >= BX0) && (h < BX1) && (v >= BY0) && (v < BY1) && !in_field;
      in_preview = (h >= PX0) && (h < PX1) && (v >= FY0) && (v < PY1);
      la_win     = (h >= LAX0) && (h < LAX1) && (v >= FY0) && (v < FY1);
      rel        = 12'(h - LAX0);
      offset     = rel & O_MASK;
      row        = 12'(v - FY0) >> CSH;
      col        = rel >> CSH;
      query_next = (12'd19 - row) * 12'd10 + col;
   end

   always_comb begin
      rgb_next = 8'h00;
      if (in_vis) begin
         if (in_field) begin
            if (bus.game_over && (cell_reg != 3'd0))
               rgb_next = 8'h49;
            else
               rgb_next = palette(cell_reg);
         end else if (in_border) begin
            rgb_next = 8'h92;
         end else if (in_preview) begin
            rgb_next = palette(bus.next_piece);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         query_pos       <= '0;
         cell_reg        <= '0;
         rgb_reg         <= '0;
         hsync_reg       <= 1'b1;
         vsync_reg       <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         rgb_reg         <= rgb_next;
         hsync_reg       <= !((h >= HS_BEG) && (h <= HS_END));
         vsync_reg       <= !((v >= VS_BEG) && (v <= VS_END));
         frame_start_reg <= (h == 10'd0) && (v == V_VIS);
         if (la_win && (offset == O_ISSUE))
            query_pos <= query_next;
         if (la_win && (offset == O_CAPT))
            cell_reg <= bus.display_query_res;
      end
   end

   assign bus.display_query_pos = query_pos;
   assign bus.rgb               = rgb_reg;
   assign bus.hsync             = hsync_reg;
   assign bus.vsync             = vsync_reg;
   assign bus.frame_start       = frame_start_reg;
endmodule

// File: tb/tb_tetris_renderer.sv
// tb/tb_tetris_renderer.sv - directed scoreboard bench for tetris_renderer
module tb_tetris_renderer;
   logic clk = 1'b0;
   logic reset;
   logic stub_const = 1'b0;

   tetris_renderer_if bus();

   tetris_renderer #(.CELL_PX(16), .FIELD_X0(240), .FIELD_Y0(80)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Engine stub: one-cycle registered response.
   always @(posedge clk)
      bus.display_query_res <= stub_const ? 3'd3 : bus.display_query_pos[2:0];

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pass_no = 0;
   int hs_low, vs_low, fs_cnt, fs_first;
   int go1_n, go1_err, go2_n, go2_err;

   localparam int K_RGB = 0, K_POS = 1, K_HS = 2, K_VS = 3, K_FS = 4;

   function automatic logic [31:0] observe(int kind);
      case (kind)
         K_RGB:   observe = {24'd0, bus.rgb};
         K_POS:   observe = {20'd0, bus.display_query_pos};
         K_HS:    observe = {31'd0, bus.hsync};
         K_VS:    observe = {31'd0, bus.vsync};
         default: observe = {31'd0, bus.frame_start};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input int kind, input logic [31:0] val, input string tag);
      exp_t e;
      int i;
      e.cyc = c; e.kind = kind; e.val = val; e.tag = tag;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endtask

   // Expected pixel at raster position (x,y) appears one cycle later.
   task automatic push_px(input int x, input int y, input logic [7:0] val, input string tag);
      push(y * 800 + x + 1, K_RGB, {24'd0, val}, tag);
   endtask

   task automatic start_pass(input int p);
      pass_no = p;
      cyc = 0;
      hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = -1;
      go1_n = 0; go1_err = 0; go2_n = 0; go2_err = 0;
      reset = 1'b1;
   endtask

   task automatic run_until(input int target);
      int ph, pv;
      exp_t e;
      while (cyc < target) begin
         @(negedge clk);
         cyc++;
         ph = (cyc - 1) % 800;
         pv = (cyc - 1) / 800;
         if (cyc >= 801 && cyc < 1601 && bus.hsync === 1'b0) hs_low++;
         if (bus.vsync === 1'b0) vs_low++;
         if (bus.frame_start === 1'b1) begin
            if (fs_cnt == 0) fs_first = cyc;
            fs_cnt++;
         end
         if (pass_no == 2 && ph >= 240 && ph < 400) begin
            if (pv >= 80 && pv < 240) begin
               go1_n++;
               if (bus.rgb !== 8'h49) go1_err++;
            end else if (pv >= 240 && pv < 400) begin
               go2_n++;
               if (bus.rgb !== 8'h1C) go2_err++;
            end
         end
         while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.kind), e.val);
         end
      end
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_rgb"},   {24'd0, bus.rgb}, 32'h0);
      chk({pfx, "_pos"},   {20'd0, bus.display_query_pos}, 32'h0);
      chk({pfx, "_hsync"}, {31'd0, bus.hsync}, 32'h1);
      chk({pfx, "_vsync"}, {31'd0, bus.vsync}, 32'h1);
      chk({pfx, "_fs"},    {31'd0, bus.frame_start}, 32'h0);
   endtask

   initial begin
      reset = 1'b0;
      bus.next_piece = 3'd4;
      bus.game_over = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_values("por");

      // Pass 1: stub echoes pos[2:0].
      start_pass(1);
      push(656, K_HS, 1, "hsync_before_fall");
      push(657, K_HS, 0, "hsync_first_fall");
      push(752, K_HS, 0, "hsync_last_low");
      push(753, K_HS, 1, "hsync_rise");
      push(80 * 800 + 237, K_POS, 190, "pos_v80_c0");
      push(80 * 800 + 239, K_POS, 190, "pos_v80_c0_held");
      push(80 * 800 + 253, K_POS, 191, "pos_v80_c1");
      push(80 * 800 + 381, K_POS, 199, "pos_v80_c9");
      push(80 * 800 + 500, K_POS, 199, "pos_v80_hold_outside");
      push_px(239, 80, 8'h92, "px_left_border_v80");
      push_px(240, 80, 8'h03, "px_cell0_first");
      push_px(255, 80, 8'h03, "px_cell0_last");
      push_px(256, 80, 8'h1F, "px_cell1_first");
      push_px(271, 80, 8'h1F, "px_cell1_last");
      push_px(399, 80, 8'h1F, "px_cell9_last");
      push_px(400, 80, 8'h92, "px_right_border_in");
      push_px(403, 80, 8'h92, "px_right_border_edge");
      push_px(404, 80, 8'h00, "px_past_border");
      push_px(420, 90, 8'hFC, "px_preview_np4");
      push_px(238, 200, 8'h92, "px_border_238_200");
      push(300 * 800 + 290, K_RGB, 32'h1F, "px_before_reset");
      push(300 * 800 + 290, K_POS, 63, "pos_before_reset");
      run_until(91 * 800);
      bus.next_piece = 3'd1;
      push_px(420, 91, 8'hE0, "px_preview_np1");
      run_until(300 * 800 + 290);
      chk("fs_none_pass1", fs_cnt, 0);
      chk("sb_drained_pass1", sb.size(), 0);

      // Asynchronous reset mid-frame, checked before any clock edge.
      #1;
      reset = 1'b0;
      stub_const = 1'b1;
      bus.game_over = 1'b1;
      #1;
      chk_reset_values("async");
      repeat (3) @(negedge clk);

      // Pass 2: stub returns 3 everywhere; game over for the upper half of the field.
      start_pass(2);
      push(384 * 800 + 237, K_POS, 0, "pos_v384_c0");
      push(384 * 800 + 381, K_POS, 9, "pos_v384_c9");
      push(384000, K_FS, 0, "fs_before");
      push(384001, K_FS, 1, "fs_pulse");
      push(384002, K_FS, 0, "fs_after");
      push(392000, K_VS, 1, "vsync_before_fall");
      push(392001, K_VS, 0, "vsync_fall");
      push(393600, K_VS, 0, "vsync_last_low");
      push(393601, K_VS, 1, "vsync_rise");
      run_until(240 * 800);
      bus.game_over = 1'b0;
      run_until(394000);

      chk("hsync_low_per_line", hs_low, 96);
      chk("vsync_low_per_frame", vs_low, 1600);
      chk("fs_count", fs_cnt, 1);
      chk("fs_first_cycle", fs_first, 384001);
      chk("go1_pixel_count", go1_n, 25600);
      chk("go1_pixels_not_49", go1_err, 0);
      chk("go0_pixel_count", go2_n, 25600);
      chk("go0_pixels_not_1c", go2_err, 0);
      chk("sb_drained_pass2", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tetris_renderer.md
# tetris_renderer

Pixel-clock video scanner that sits directly downstream of the Tetris game engine. It walks the 640x480@60 raster, drives the engine's `display_query_pos` with one-cell lookahead, and latches the returned cell value `display_query_res`. It then emits registered RGB332 plus VGA syncs for the 10x20 playfield, its border and a next-piece swatch. It also emits a once-per-frame strobe that upstream logic uses as a fall-tick source.

## Interface
- `CELL_PX`, 16: cell edge in pixels (power of two, ≥8).
- `FIELD_X0`, 240: left pixel column of the playfield; must satisfy `FIELD_X0 ≥ CELL_PX + 4`.
- `FIELD_Y0`, 80: top pixel line of the playfield; must satisfy `FIELD_Y0 ≥ 4`.
- `clk`  in  1  pixel clock, 25 MHz; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `display_query_res`  in  3  cell value, 0 = empty, 1..7 = piece id. It is valid 2 cycles after `display_query_pos` becomes stable.
- `next_piece`  in  3  upcoming piece id, 1..7.
- `game_over`  in  1  level; greys out occupied cells.
- `display_query_pos`  out  12  cell index sent to the engine, `y*10+x`; row 19 is the top row.
- `hsync`, `vsync`  out  1  active-low syncs.
- `rgb`  out  8  RGB332 pixel; 0 outside the visible area.
- `frame_start`  out  1  one-cycle pulse at the first cycle of line 480.

## Operation
- Counters: `h` runs 0..799 and `v` runs 0..524. `h` wraps to 0 and increments `v`; `v` wraps to 0 after 524.
- Horizontal sync is low for `h` in 656..751. Vertical sync is low for `v` in 490..491.
- Field region: `h` in [FIELD_X0, FIELD_X0+10·CELL_PX) and `v` in [FIELD_Y0, FIELD_Y0+20·CELL_PX).
- Screen row: `row = (v−FIELD_Y0)/CELL_PX`, range 0..19.
- Border: a 4-pixel ring outside the field region, colour 8'h92.
- Preview swatch: one `CELL_PX` square whose top-left corner is at (FIELD_X0+11·CELL_PX, FIELD_Y0). It is filled with palette[`next_piece`].
- Lookahead window: `h` in [FIELD_X0−CELL_PX, FIELD_X0+9·CELL_PX) while `v` is in the field rows.
  - Offset `o = (h−FIELD_X0+CELL_PX) mod CELL_PX`.
  - Target column `col = (h−FIELD_X0+CELL_PX)/CELL_PX`, range 0..9.
- Query issue: the registered `display_query_pos` loads `(19−row)·10+col` when `o == CELL_PX−4`. It is held through `o == CELL_PX−1`.
- Query result: `cell_reg` captures `display_query_res` on the clock edge where `o == CELL_PX−1`. So `cell_reg` holds the value of the cell that `h` enters on the next cycle.
- Outside the lookahead window: `display_query_pos` holds its last value and `cell_reg` holds.
- Palette (id → rgb): 0→00, 1→E0, 2→A3, 3→1C, 4→FC, 5→F0, 6→03, 7→1F.
- `game_over` = 1: any nonzero cell is drawn as 8'h49.
- Pixel priority: field cell, then border, then preview, then 0.
- Outside visible (`h` ≥ 640 or `v` ≥ 480): `rgb` = 0.

## Timing
- `rgb`, `hsync`, `vsync` and `frame_start` are registered functions of (`h`,`v`) from the previous cycle. Latency is exactly 1 cycle for all four, so sync-to-pixel alignment is preserved.
- Reset values (asynchronous, while `reset` is low):
  - `h`, `v`, `cell_reg` = 0;
  - `display_query_pos` = 0;
  - `rgb` = 0;
  - `hsync` = `vsync` = 1;
  - `frame_start` = 0.
- First active cycle after `reset` deasserts: `h` = 0 and `v` = 0.
- Reset deasserting mid-line or mid-frame restarts the raster at (0,0). There is no partial-frame recovery.
- `frame_start` period is 800·525 = 420000 cycles.
- The query is held stable for 4 cycles before capture, covering the engine's 1-cycle RAM read plus its combinational overlay.
- A change of the engine's piece overlay mid-cell takes effect from the next lookahead.
- `next_piece` and `game_over` are sampled combinationally into the output register each cycle; there is no extra latency.

## Test plan
- Sync timing:
  - Run 2 frames after reset.
  - `hsync` is low 96 cycles per 800; `vsync` is low for 1600 cycles per 420000.
  - First `hsync` fall occurs at cycle 657 after reset release (656 + 1 register).
- Query sequence on line `v` = 80:
  - `display_query_pos` becomes 190 at `h` = 236 and 191 at `h` = 252, continuing up to 199.
  - On line `v` = 384 (row 19) the values are 0..9.
- Latency model:
  - Engine stub returns `pos[2:0]` one cycle after `pos`.
  - Pixels at `h` = 241..256 of line 80 show palette[190 mod 8 = 6] = 03, output 1 cycle late.
  - The next 16 pixels show palette[7] = 1F.
- Border/preview:
  - With `next_piece` = 4, the pixel at (238, 200) is 92 and the pixel at (420, 90) is FC.
  - With `next_piece` changed to 1 mid-frame, the next swatch pixel is E0.
- Game over: with the stub returning 3 everywhere and `game_over` = 1, every field pixel is 49; with `game_over` = 0 they are 1C.
- Async reset mid-frame:
  - Assert `reset` low at `v` = 300 for 3 cycles without a clock edge.
  - Outputs go to reset values immediately.
  - After release, `frame_start` next pulses at cycle 480·800 + 1.
